// File: rtl/param_sync_counter.sv
// param_sync_counter: parametrised up/down modulo counter with load, clears, tc and a registered wrap pulse
//   Optional feature macro: CNT_SATURATE_EN (saturate at the ends instead of wrapping; wrap_o tied low)
//   Parameters: WIDTH (>= 2), MODULUS (2..2**WIDTH), count range 0..MODULUS-1
//   Ports:
//     clock_i     rising-edge clock
//     clear_i     asynchronous active-high reset (q_o = 0, wrap_o = 0)
//     sync_clr_i  synchronous clear, highest edge priority
//     load_i      synchronous load of load_val_i (clamped to MODULUS-1)
//     load_val_i  load value
//     cnt_en_i    count enable
//     up_dn_i     1 = count up, 0 = count down
//     q_o         registered count
//     tc_o        combinational terminal count
//     wrap_o      registered one-cycle pulse when the count wraps
module param_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clock_i,
  input  logic             clear_i,
  input  logic             sync_clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             cnt_en_i,
  input  logic             up_dn_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             wrap_o
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] q_q, q_d, step_v, load_v;
  logic             wrap_q, wrap_d, at_end;
  assign at_end = up_dn_i ? (q_q == MAX) : (q_q == '0);
  assign tc_o   = cnt_en_i & at_end;
  assign load_v = (load_val_i > MAX) ? MAX : load_val_i;
`ifdef CNT_SATURATE_EN
  // At the terminal point the count simply holds.
  assign step_v = at_end ? q_q : (up_dn_i ? q_q + WIDTH'(1) : q_q - WIDTH'(1));
  assign wrap_d = 1'b0;
`else
  // Explicit wrap targets keep q below MODULUS even when MODULUS < 2**WIDTH.
  assign step_v = up_dn_i ? (at_end ? '0 : q_q + WIDTH'(1)) : (at_end ? MAX : q_q - WIDTH'(1));
  assign wrap_d = ~sync_clr_i & ~load_i & tc_o;
`endif
  assign q_d = sync_clr_i ? '0 : load_i ? load_v : cnt_en_i ? step_v : q_q;
  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end
  assign q_o    = q_q;
  assign wrap_o = wrap_q;
endmodule
